// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if: debug-load, redirect and decode handshake bundle for the fetch queue
interface if_fetch_queue_if #(
  parameter int NB_DATA = 32,
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 4
);
  logic                     debug_unit_i;
  logic                     en_write_i;
  logic [ADDR_W-1:0]        wr_addr_i;
  logic [NB_DATA-1:0]       inst_load_i;
  logic                     redirect_i;
  logic [ADDR_W-1:0]        redirect_addr_i;
  logic                     ready_i;
  logic                     valid_o;
  logic [NB_DATA-1:0]       instruction_o;
  logic [ADDR_W-1:0]        pc_o;
  logic                     halted_o;
  logic [$clog2(DEPTH):0]   count_o;
  modport master (
    output debug_unit_i, en_write_i, wr_addr_i, inst_load_i, redirect_i, redirect_addr_i, ready_i,
    input  valid_o, instruction_o, pc_o, halted_o, count_o
  );
  modport slave (
    input  debug_unit_i, en_write_i, wr_addr_i, inst_load_i, redirect_i, redirect_addr_i, ready_i,
    output valid_o, instruction_o, pc_o, halted_o, count_o
  );
endinterface

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch with debug-loadable memory and a prefetch FIFO to decode
module if_fetch_queue #(
  parameter int             NB_DATA     = 32,
  parameter int             ADDR_W      = 10,
  parameter int             DEPTH       = 4,
  parameter logic [5:0]     HALT_OPCODE = 6'b111111,
  parameter logic [31:0]    NOP_WORD    = 32'hF8000000
) (
  input  logic         clock_i,
  input  logic         reset_i,
  if_fetch_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;
  logic [1:0]         state;
  logic [NB_DATA-1:0] mem [2**ADDR_W];
  logic [NB_DATA-1:0] rd_data;
  logic [ADDR_W-1:0]  pc, tag;
  logic               inflight;
  logic [NB_DATA-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0]  q_pc [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               dbg, redir, head_valid, pop, push, halt_push, issue;
  // a pop frees a slot in the same cycle, so the credit compares against DEPTH + pop
  always_comb begin
    dbg        = bus.debug_unit_i;
    redir      = bus.redirect_i & ~dbg;
    head_valid = (count != '0) & ~dbg;
    pop        = head_valid & bus.ready_i & ~redir;
    push       = inflight & ~dbg & ~redir;
    halt_push  = push && (rd_data[NB_DATA-1 -: 6] == HALT_OPCODE);
    issue      = ~dbg & ~redir & ~halt_push & (state != ST_HALT) &
                 ((CW+1)'(count) + (CW+1)'(inflight) < (CW+1)'(DEPTH) + (CW+1)'(pop));
  end
  always_ff @(posedge clock_i) begin
    if (dbg && bus.en_write_i) mem[bus.wr_addr_i] <= bus.inst_load_i;
    if (issue) rd_data <= mem[pc];
  end
  always_ff @(posedge clock_i) begin
    if (push) begin
      q_data[wr_ptr] <= rd_data;
      q_pc[wr_ptr]   <= tag + ADDR_W'(1);
    end
  end
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state    <= ST_RUN;
      pc       <= '0;
      tag      <= '0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (dbg) begin
      state    <= ST_LOAD;
      pc       <= '0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redir) begin
      state    <= ST_RUN;
      pc       <= bus.redirect_addr_i;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= halt_push ? ST_HALT : (state == ST_LOAD) ? ST_RUN : state;
      inflight <= issue;
      if (issue) begin
        pc  <= pc + ADDR_W'(1);
        tag <= pc;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign bus.valid_o       = head_valid;
  assign bus.instruction_o = head_valid ? q_data[rd_ptr] : NOP_WORD;
  assign bus.pc_o          = head_valid ? q_pc[rd_ptr] : '0;
  assign bus.halted_o      = (state == ST_HALT);
  assign bus.count_o       = count;
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: table vectors, directed corner cases and random traffic against a queue model
module tb_if_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'hF8000000;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  if_fetch_queue_if #(.NB_DATA(32), .ADDR_W(10), .DEPTH(DEPTH)) bus ();
  if_fetch_queue_if #(.NB_DATA(32), .ADDR_W(4), .DEPTH(DEPTH)) sbus ();
  if_fetch_queue dut (.clock_i(clk), .reset_i(rst_n), .bus(bus));
  if_fetch_queue #(.ADDR_W(4)) dut_small (.clock_i(clk), .reset_i(rst_n), .bus(sbus));
  typedef struct { logic [31:0] d; logic [9:0] p; } ent_t;
  typedef struct { bit ready; bit valid; logic [9:0] pc; logic [2:0] cnt; } vec_t;
  int checks = 0;
  int failures = 0;
  logic [31:0] img [1024];
  ent_t q[$];
  bit pend = 0;
  bit mhalt = 0;
  logic [31:0] pdata = '0;
  logic [9:0] ppc = '0, mpc = '0;
  vec_t tab [20];
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'h3F) w[31] = 1'b0;
    return w;
  endfunction
  task automatic model_reset();
    q.delete(); pend = 0; mpc = '0; mhalt = 0;
  endtask
  task automatic model_step();
    if (bus.debug_unit_i) begin
      if (bus.en_write_i) img[bus.wr_addr_i] = bus.inst_load_i;
      model_reset();
    end else if (bus.redirect_i) begin
      model_reset();
      mpc = bus.redirect_addr_i;
    end else begin
      if (q.size() > 0 && bus.ready_i) void'(q.pop_front());
      if (pend) begin
        q.push_back('{pdata, ppc + 10'd1});
        if (pdata[31:26] == 6'h3F) mhalt = 1;
      end
      pend = 0;
      if (!mhalt && q.size() < DEPTH) begin
        pend = 1; pdata = img[mpc]; ppc = mpc; mpc = mpc + 10'd1;
      end
    end
  endtask
  task automatic check_model();
    bit v;
    v = !bus.debug_unit_i && q.size() > 0;
    chk("m_valid", bus.valid_o, v);
    chk("m_instr", bus.instruction_o, v ? q[0].d : NOP);
    chk("m_pc", bus.pc_o, v ? q[0].p : 10'd0);
    chk("m_count", bus.count_o, q.size());
    chk("m_halted", bus.halted_o, mhalt);
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask
  task automatic set_idle();
    bus.debug_unit_i = 0; bus.en_write_i = 0; bus.redirect_i = 0; bus.ready_i = 1;
  endtask
  initial begin
    ent_t got[$];
    for (int i = 0; i < 20; i++) begin
      tab[i].ready = !(i >= 5 && i < 15);
      tab[i].valid = i > 0;
      tab[i].pc    = i == 0 ? 10'd0 : i < 5 ? 10'(i) : i < 15 ? 10'd4 : 10'(i - 10);
      tab[i].cnt   = i == 0 ? 3'd0 : i < 5 ? 3'd1 : i < 15 ? 3'((i - 3 > 4) ? 4 : i - 3) : 3'd3;
    end
    bus.debug_unit_i = 1; bus.en_write_i = 0; bus.wr_addr_i = '0; bus.inst_load_i = '0;
    bus.redirect_i = 0; bus.redirect_addr_i = '0; bus.ready_i = 0;
    sbus.debug_unit_i = 0; sbus.en_write_i = 0; sbus.wr_addr_i = '0; sbus.inst_load_i = '0;
    sbus.redirect_i = 0; sbus.redirect_addr_i = '0; sbus.ready_i = 1;
    #2 rst_n = 0;
    #8;
    chk("rst_valid", bus.valid_o, 1'b0);
    chk("rst_instr", bus.instruction_o, NOP);
    chk("rst_pc", bus.pc_o, 10'd0);
    chk("rst_count", bus.count_o, 3'd0);
    chk("rst_halted", bus.halted_o, 1'b0);
    #2 rst_n = 1;
    model_reset();
    // fill the whole memory so every fetch has a known expected word
    for (int i = 0; i < 1024; i++) begin
      bus.en_write_i = 1; bus.wr_addr_i = 10'(i);
      bus.inst_load_i = i == 0 ? 32'h20010005 : i == 1 ? 32'h20010006 :
                        i == 2 ? 32'h20020006 : i == 3 ? 32'h20020007 : rand_word();
      tick();
    end
    set_idle();
    for (int i = 0; i < 20; i++) begin
      bus.ready_i = tab[i].ready;
      tick();
      chk($sformatf("tab%0d_valid", i), bus.valid_o, tab[i].valid);
      chk($sformatf("tab%0d_pc", i), bus.pc_o, tab[i].pc);
      chk($sformatf("tab%0d_count", i), bus.count_o, tab[i].cnt);
      chk($sformatf("tab%0d_instr", i), bus.instruction_o, tab[i].valid ? img[tab[i].pc - 10'd1] : NOP);
    end
    bus.redirect_i = 1; bus.redirect_addr_i = 10'h040;
    tick();
    chk("redir_valid0", bus.valid_o, 1'b0);
    chk("redir_count0", bus.count_o, 3'd0);
    bus.redirect_i = 0;
    tick();
    chk("redir_valid1", bus.valid_o, 1'b0);
    tick();
    chk("redir_valid2", bus.valid_o, 1'b1);
    chk("redir_pc2", bus.pc_o, 10'h041);
    chk("redir_instr2", bus.instruction_o, img[10'h040]);
    bus.debug_unit_i = 1; bus.en_write_i = 1; bus.wr_addr_i = 10'd5; bus.inst_load_i = 32'hFC000000;
    tick();
    set_idle();
    for (int i = 0; i < 20; i++) begin
      if (bus.valid_o) got.push_back('{bus.instruction_o, bus.pc_o});
      tick();
    end
    chk("halt_delivered", got.size(), 6);
    for (int i = 0; i < got.size() && i < 6; i++) chk($sformatf("halt_pc%0d", i), got[i].p, 10'(i + 1));
    if (got.size() > 0) chk("halt_last_instr", got[got.size() - 1].d, 32'hFC000000);
    chk("halt_flag", bus.halted_o, 1'b1);
    chk("halt_idle", bus.valid_o, 1'b0);
    bus.redirect_i = 1; bus.redirect_addr_i = 10'd0;
    tick();
    chk("halt_clear", bus.halted_o, 1'b0);
    bus.redirect_i = 0;
    tick(); tick();
    chk("resume_valid", bus.valid_o, 1'b1);
    chk("resume_pc", bus.pc_o, 10'd1);
    bus.debug_unit_i = 1; bus.en_write_i = 0;
    tick();
    set_idle();
    bus.ready_i = 0;
    repeat (4) tick();
    chk("pre_reset_count", bus.count_o, 3'd3);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", bus.valid_o, 1'b0);
    chk("arst_count", bus.count_o, 3'd0);
    chk("arst_pc", bus.pc_o, 10'd0);
    chk("arst_instr", bus.instruction_o, NOP);
    model_reset();
    #2 rst_n = 1;
    bus.ready_i = 1;
    tick(); tick();
    chk("restart_valid", bus.valid_o, 1'b1);
    chk("restart_pc", bus.pc_o, 10'd1);
    chk("restart_instr", bus.instruction_o, img[0]);
    for (int i = 0; i < 2000; i++) begin
      bus.debug_unit_i = $urandom_range(0, 99) < 1;
      bus.en_write_i = $urandom_range(0, 1);
      bus.wr_addr_i = 10'($urandom);
      bus.inst_load_i = $urandom_range(0, 19) == 0 ? 32'hFC000000 | 32'($urandom_range(0, 255)) : rand_word();
      bus.redirect_i = $urandom_range(0, 99) < 3;
      bus.redirect_addr_i = 10'($urandom);
      bus.ready_i = $urandom_range(0, 9) < 7;
      tick();
    end
    set_idle();
    sbus.debug_unit_i = 1; sbus.en_write_i = 1;
    for (int i = 0; i < 16; i++) begin
      sbus.wr_addr_i = 4'(i); sbus.inst_load_i = 32'h10000000 + 32'(i);
      tick();
    end
    sbus.debug_unit_i = 0; sbus.en_write_i = 0; sbus.redirect_i = 1; sbus.redirect_addr_i = 4'hE;
    tick();
    sbus.redirect_i = 0;
    tick(); tick();
    chk("wrap_pc_f", sbus.pc_o, 4'hF);
    chk("wrap_instr_f", sbus.instruction_o, 32'h1000000E);
    tick();
    chk("wrap_pc_0", sbus.pc_o, 4'h0);
    chk("wrap_instr_0", sbus.instruction_o, 32'h1000000F);
    tick();
    chk("wrap_pc_1", sbus.pc_o, 4'h1);
    chk("wrap_instr_1", sbus.instruction_o, 32'h10000000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised next-generation instruction-fetch stage. It holds the PC, an internal synchronous-read instruction memory loadable by the debug unit, and a DEPTH-entry prefetch FIFO. The FIFO decouples fetch from decode through a valid/ready handshake. It supports redirect with flush (branch/jump/register), stall back-pressure, and a halt-opcode stop. It sits between debug_unit/control (redirect source) and the IF/ID boundary.

Parameters:
NB_DATA, 32, instruction width in bits
ADDR_W, 10, PC/memory address width; word-addressed; memory holds 2**ADDR_W words
DEPTH, 4, prefetch FIFO entries; power of two, minimum 2
HALT_OPCODE, 6'b111111, opcode in bits [31:26] that stops fetching
NOP_WORD, 32'hF8000000, instruction driven while no entry is valid

Ports:
clock_i  in  1  system clock, rising edge
reset_i  in  1  asynchronous reset, active-low
debug_unit_i  in  1  1 = load mode: fetch off, memory writable
en_write_i  in  1  memory write strobe; honoured only when debug_unit_i=1
wr_addr_i  in  ADDR_W  debug write address
inst_load_i  in  NB_DATA  debug write data
redirect_i  in  1  redirect request; flushes FIFO and in-flight read, loads PC
redirect_addr_i  in  ADDR_W  redirect target (already muxed by control)
ready_i  in  1  decode accepts the head entry this cycle
valid_o  out  1  head entry valid
instruction_o  out  NB_DATA  head instruction; NOP_WORD when valid_o=0
pc_o  out  ADDR_W  head entry's PC+1, mod 2**ADDR_W
halted_o  out  1  halt opcode fetched; no further issue
count_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (asynchronous, reset_i=0):
  - PC=0; FIFO empty; in-flight flag=0; state=RUN unless debug_unit_i=1.
  - valid_o=0, instruction_o=NOP_WORD, pc_o=0, halted_o=0, count_o=0.
  - Memory contents are not reset.
- States:
  - LOAD: entered whenever debug_unit_i=1, from any state. Entry flushes the FIFO and the in-flight read and sets PC=0. Writes mem[wr_addr_i]<=inst_load_i when en_write_i=1. No issue; valid_o=0.
  - RUN: entered when debug_unit_i falls. Fetches.
  - HALTED: no issue; the FIFO drains normally.
  - HALTED->RUN on redirect_i. HALTED->LOAD on debug_unit_i.
- Issue (RUN only):
  - Condition: count + inflight < DEPTH, counting a same-cycle pop as freeing a slot.
  - Action: read mem[PC], PC<=PC+1 (wraps at 2**ADDR_W), inflight<=1, tag the read with the current PC.
- Return:
  - Data arrives the cycle after issue and is pushed with pc=tag+1.
  - If the pushed opcode is HALT_OPCODE: it is still enqueued, state<=HALTED, halted_o<=1. A read issued in that same cycle is discarded (never pushed).
- Latency: first issue is on the first edge after reset release. valid_o is asserted 2 cycles after reset release in an idle RUN.
- Sustained throughput: 1 instruction/cycle while ready_i=1.
- Pop: on valid_o & ready_i the head advances. Pop and push in the same cycle are both allowed, including at full, where count is unchanged.
- Redirect (redirect_i=1, RUN or HALTED), taking effect next cycle:
  - FIFO emptied; in-flight data discarded; PC<=redirect_addr_i; halted_o<=0.
  - A concurrent pop is void.
  - No issue happens in the redirect cycle.
  - The first redirected instruction appears 2 cycles after redirect_i.
- Priority: reset > debug_unit_i > redirect_i > halt > issue/pop.
- FIFO wraps with ADDR-independent read/write pointers. It never overflows: the issue credit guarantees room.
- Outputs are registered or driven directly from the FIFO head, with no combinational path from ready_i to valid_o.
- ready_i held low: fetch stops with the FIFO full (count_o=DEPTH) and the PC frozen at the next unread address.
- en_write_i with debug_unit_i=0 is ignored.

Test Plan:
- Load: debug write 0x20010005 to addr0 through addr3 = 0x20020007, then release -> valid_o at cycle 2; pc_o sequence 1,2,3,4; one instruction per cycle with ready_i=1.
- Back-pressure: DEPTH=4, ready_i=0 for 10 cycles -> count_o=4, no loss or duplication. Then ready_i=1 -> addr0..N delivered in order.
- Redirect with a full FIFO plus an in-flight read, redirect_addr_i=0x040 -> next cycle valid_o=0; 2 cycles later pc_o=0x041 with the contents of mem[0x40]; no stale entry is ever seen.
- Halt: 0xFC000000 at addr 5 -> entries 0..5 delivered, halted_o=1, no entry 6. Then redirect to 0 -> halted_o=0 and fetch resumes.
- Wrap: ADDR_W=4, start by redirect at 0xE -> pc_o sequence 0xF, 0x0, 0x1.
- Asynchronous reset mid-stream (count_o=3) -> outputs reset immediately without a clock edge. After release, fetch restarts at addr 0.
